readout_sequencer: RTL and testbench

- Downstream consumer of the oscilloscope acquisition stage, on the main `clk` domain.
- Once the acquisition stage reports `data_ready`, this block walks the sample RAMs of all channels in trigger-aligned order and streams one byte per sample to the host-link transmitter over a valid/ready handshake.
- It drives the RAM read port (`rden`, `rdaddress`) and a channel select.
- It reports `busy` and a one-cycle `done` pulse so the command layer can re-arm the trigger.

---
 rtl/readout_sequencer.sv | 165 ++++++++++++++++
 tb/tb_readout_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sequencer.sv
// Streams the trigger-aligned contents of every channel sample RAM to the host link,
// one byte per handshake, channel 0 first; reports busy and a one-cycle done pulse.
module readout_sequencer #(
  parameter int ram_width = 10,
  parameter int nchan     = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_read,
  input  logic                 abort,
  input  logic                 data_ready,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic [ram_width-1:0] triggerpoint,
  input  logic [ram_width-1:0] nsmp,
  input  logic [7:0]           ram_q,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  output logic [2:0]           chan_sel,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  // state  | meaning
  // IDLE   | waiting for start_read with data_ready
  // ADDR   | rden high, address of sample k presented
  // LAT    | RAM read latency
  // SEND   | byte offered on tx_data until accepted
  // FINISH | done pulse, back to IDLE
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_LAT    = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam int         KW        = ram_width + 1;
  localparam logic [2:0] LAST_CHAN = 3'(nchan - 1);

  logic [2:0]           state_q, state_d;
  logic [ram_width-1:0] base_q, base_d;
  logic [ram_width-1:0] nsmp_q, nsmp_d;
  logic [KW-1:0]        k_q, k_d;
  logic [2:0]           chan_q, chan_d;
  logic                 rden_q, rden_d;
  logic [ram_width-1:0] rdaddr_q, rdaddr_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [KW-1:0]        nsmp_ext;
  logic                 last_smp;
  logic [ram_width-1:0] start_base;

  // nsmp == 0 stands for a full RAM, hence the extra top bit
  assign nsmp_ext   = {(nsmp_q == '0), nsmp_q};
  assign last_smp   = (k_q == nsmp_ext - KW'(1));
  assign start_base = wraddress_triggerpoint - triggerpoint;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    nsmp_d     = nsmp_q;
    k_d        = k_q;
    chan_d     = chan_q;
    rden_d     = 1'b0;
    rdaddr_d   = rdaddr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_read && data_ready) begin
          base_d   = start_base;
          nsmp_d   = nsmp;
          k_d      = '0;
          chan_d   = 3'd0;
          busy_d   = 1'b1;
          rden_d   = 1'b1;
          rdaddr_d = start_base;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: state_d = S_LAT;
      S_LAT: begin
        tx_data_d  = ram_q;
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (!last_smp) begin
            k_d      = k_q + KW'(1);
            rden_d   = 1'b1;
            rdaddr_d = base_q + k_q[ram_width-1:0] + ram_width'(1);
            state_d  = S_ADDR;
          end else if (chan_q != LAST_CHAN) begin
            chan_d   = chan_q + 3'd1;
            k_d      = '0;
            rden_d   = 1'b1;
            rdaddr_d = base_q;
            state_d  = S_ADDR;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // abort wins over everything, including a handshake on the same edge
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
      rden_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      nsmp_q     <= '0;
      k_q        <= '0;
      chan_q     <= 3'd0;
      rden_q     <= 1'b0;
      rdaddr_q   <= '0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nsmp_q     <= nsmp_d;
      k_q        <= k_d;
      chan_q     <= chan_d;
      rden_q     <= rden_d;
      rdaddr_q   <= rdaddr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rden      = rden_q;
  assign rdaddress = rdaddr_q;
  assign chan_sel  = chan_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: a RAM model feeds the DUT and every readout
// is compared with the byte/address/channel stream computed from the trigger arithmetic.
module tb_readout_sequencer;

  localparam int RW    = 10;
  localparam int NCHAN = 4;
  localparam int DEPTH = 1 << RW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_read = 1'b0;
  logic          abort = 1'b0;
  logic          data_ready = 1'b0;
  logic [RW-1:0] wtp_r = '0;
  logic [RW-1:0] tp_r = '0;
  logic [RW-1:0] nsmp_r = '0;
  logic [7:0]    ram_q = 8'd0;
  logic          rden;
  logic [RW-1:0] rdaddress;
  logic [2:0]    chan_sel;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          done;

  readout_sequencer #(.ram_width(RW), .nchan(NCHAN)) dut (
    .clk(clk), .rstn(rstn), .start_read(start_read), .abort(abort),
    .data_ready(data_ready), .wraddress_triggerpoint(wtp_r), .triggerpoint(tp_r),
    .nsmp(nsmp_r), .ram_q(ram_q), .rden(rden), .rdaddress(rdaddress),
    .chan_sel(chan_sel), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8][DEPTH];
  always @(posedge clk) if (rden) ram_q <= mem[chan_sel][rdaddress];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got_b[$];
  int         got_a[$];
  int         got_c[$];
  int         done_cnt, valid_cnt, busy_cyc, first_valid, stable_err, busy_at_done;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'd0;

  initial begin
    done_cnt = 0; valid_cnt = 0; busy_cyc = 0; first_valid = -1;
    stable_err = 0; busy_at_done = -1;
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      got_b.push_back(tx_data);
      got_c.push_back(int'(chan_sel));
    end
    if (rden) got_a.push_back(int'(rdaddress));
    if (done) begin
      done_cnt++;
      busy_at_done = int'(busy);
    end
    if (tx_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (busy) busy_cyc++;
    if (prev_v && !prev_r && (!tx_valid || tx_data !== prev_d)) stable_err++;
    prev_v = tx_valid;
    prev_r = tx_ready;
    prev_d = tx_data;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit rnd);
    for (int c = 0; c < 8; c++)
      for (int a = 0; a < DEPTH; a++)
        mem[c][a] = rnd ? 8'($urandom) : 8'(a);
  endtask

  task automatic clear_mon();
    got_b.delete(); got_a.delete(); got_c.delete();
    done_cnt = 0; first_valid = -1; stable_err = 0; busy_cyc = 0; busy_at_done = -1;
  endtask

  // mode 0: full readout, 1: abort after 6th byte, 2: reset mid-SEND after 6th byte
  task automatic run(input string name, input int wtp, input int tp, input int ns,
                     input bit bp, input int mode, input bit perturb);
    int base, nper, total, s, bad_b, bad_a, bad_c, vsnap, lim;
    bit fin;
    logic [7:0] exp_b[$];
    int exp_a[$];
    int exp_c[$];
    base  = ((wtp - tp) % DEPTH + DEPTH) % DEPTH;
    nper  = (ns == 0) ? DEPTH : ns;
    total = NCHAN * nper;
    for (int c = 0; c < NCHAN; c++)
      for (int k = 0; k < nper; k++) begin
        exp_a.push_back((base + k) % DEPTH);
        exp_b.push_back(mem[c][(base + k) % DEPTH]);
        exp_c.push_back(c);
      end
    @(posedge clk); #1;
    clear_mon();
    wtp_r = RW'(wtp); tp_r = RW'(tp); nsmp_r = RW'(ns);
    data_ready = 1'b1; start_read = 1'b1; tx_ready = 1'b1; s = cyc;
    fin = 1'b0;
    for (int i = 0; i < 30000 && !fin; i++) begin
      @(posedge clk); #1;
      start_read = 1'b0; abort = 1'b0;
      tx_ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (perturb && i == 4) start_read = 1'b1;
      if (perturb && i == 8) begin
        data_ready = 1'b0;
        wtp_r = RW'($urandom); tp_r = RW'($urandom); nsmp_r = RW'($urandom);
      end
      if (mode == 0 && done_cnt > 0) fin = 1'b1;
      if (mode == 1 && got_b.size() == 6) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk({name, "_abort_busy"}, busy, 0);
        chk({name, "_abort_valid"}, tx_valid, 0);
        fin = 1'b1;
      end
      if (mode == 2 && got_b.size() == 6 && tx_valid) begin
        tx_ready = 1'b0;
        rstn = 1'b0;
        #1;
        chk({name, "_rst_outputs"}, {rden, rdaddress, chan_sel, tx_data, tx_valid, busy, done}, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        fin = 1'b1;
      end
    end
    chk({name, "_timeout"}, fin, 1);
    if (mode == 0) begin
      repeat (3) @(posedge clk);
      #1;
      bad_b = 0; bad_a = 0; bad_c = 0;
      lim = (got_b.size() < total) ? got_b.size() : total;
      for (int i = 0; i < lim; i++) begin
        if (got_b[i] !== exp_b[i]) bad_b++;
        if (got_c[i] !== exp_c[i]) bad_c++;
      end
      lim = (got_a.size() < total) ? got_a.size() : total;
      for (int i = 0; i < lim; i++) if (got_a[i] !== exp_a[i]) bad_a++;
      chk({name, "_byte_count"}, got_b.size(), total);
      chk({name, "_read_count"}, got_a.size(), total);
      chk({name, "_bytes"}, bad_b, 0);
      chk({name, "_addrs"}, bad_a, 0);
      chk({name, "_chans"}, bad_c, 0);
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_busy_at_done"}, busy_at_done, 0);
      chk({name, "_latency"}, first_valid - s, 3);
      chk({name, "_stable"}, stable_err, 0);
      if (!bp) chk({name, "_busy_cycles"}, busy_cyc, 3 * total);
      chk({name, "_idle_busy"}, busy, 0);
    end else begin
      vsnap = valid_cnt;
      repeat (20) @(posedge clk);
      #1;
      bad_b = 0;
      for (int i = 0; i < got_b.size() && i < 6; i++) if (got_b[i] !== exp_b[i]) bad_b++;
      chk({name, "_post_valid"}, valid_cnt - vsnap, 0);
      chk({name, "_byte_count"}, got_b.size(), 6);
      chk({name, "_bytes"}, bad_b, 0);
      chk({name, "_no_done"}, done_cnt, 0);
      chk({name, "_idle_busy"}, busy, 0);
    end
  endtask

  initial begin
    int vsnap;
    fill(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rden", rden, 0);
    chk("reset_rdaddress", rdaddress, 0);
    chk("reset_chan_sel", chan_sel, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // start without data_ready must do nothing
    clear_mon();
    vsnap = valid_cnt;
    wtp_r = 10'd300; tp_r = 10'd100; nsmp_r = 10'd4;
    data_ready = 1'b0; start_read = 1'b1;
    @(posedge clk); #1;
    start_read = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("gate_busy", busy_cyc, 0);
    chk("gate_reads", got_a.size(), 0);
    chk("gate_done", done_cnt, 0);
    chk("gate_valid", valid_cnt - vsnap, 0);

    run("basic", 300, 100, 4, 1'b0, 0, 1'b0);
    run("wrap", 5, 10, 8, 1'b0, 0, 1'b0);
    chk("wrap_first_addr", got_a.size() > 0 ? got_a[0] : -1, 1019);
    chk("wrap_sixth_addr", got_a.size() > 5 ? got_a[5] : -1, 0);
    run("backpressure", 300, 100, 4, 1'b1, 0, 1'b0);
    run("busy_start", 300, 100, 4, 1'b0, 0, 1'b1);

    fill(1'b1);
    for (int r = 0; r < 4; r++)
      run("random", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));

    run("abort", 300, 100, 4, 1'b0, 1, 1'b0);
    run("reset_mid", 700, 50, 4, 1'b1, 2, 1'b0);
    run("full_ram", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
        0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
